// File: rtl/uart_cfg_pkg.sv
// Shared types, register codes and SETUP word packing for the UART configuration bank.
// The UART_CFG_LOCK_EN build adds a sticky lock bit at SETUP[15].
package uart_cfg_pkg;

  localparam logic [1:0] REG_SETUP  = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_ACTIVE = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned CFG_W = 22;

  // Member order makes the packed value match the ch_cfg_o layout, parity_en at bit 0.
  typedef struct packed {
    logic [15:0] clkdiv;
    logic        rx_en;
    logic        tx_en;
    logic        stop2;
    logic [1:0]  bits;
    logic        parity_en;
  } uart_ch_cfg_t;

  localparam uart_ch_cfg_t CFG_RST = '{
    clkdiv:    16'd434,
    rx_en:     1'b0,
    tx_en:     1'b0,
    stop2:     1'b0,
    bits:      2'b11,
    parity_en: 1'b0
  };

  typedef enum logic {StClean, StPending} chan_state_e;

  function automatic uart_ch_cfg_t cfg_reset(input logic [15:0] clkdiv);
    uart_ch_cfg_t c;
    c = CFG_RST;
    c.clkdiv = clkdiv;
    return c;
  endfunction

  function automatic logic [31:0] pack_setup(input uart_ch_cfg_t c);
    return {c.clkdiv, 6'b0, c.rx_en, c.tx_en, 4'b0, c.stop2, c.bits, c.parity_en};
  endfunction

  // A zero divider is stored as 1 so the baud generator never sees a zero period.
  function automatic uart_ch_cfg_t unpack_setup(input logic [31:0] w);
    uart_ch_cfg_t c;
    logic         unused_w;
    unused_w    = ^{w[15:10], w[7:4]};
    c.clkdiv    = (w[31:16] == 16'd0) ? 16'd1 : w[31:16];
    c.rx_en     = w[9];
    c.tx_en     = w[8];
    c.stop2     = w[3];
    c.bits      = w[2:1];
    c.parity_en = w[0];
    return c;
  endfunction

endpackage

// File: rtl/uart_cfg_chan.sv
// One channel: shadow and active configuration, commit FSM and the update pulse.
// UART_CFG_LOCK_EN adds the sticky lock flops; otherwise the lock outputs are tied low.
module uart_cfg_chan
  import uart_cfg_pkg::*;
#(
  parameter logic [15:0] RST_CLKDIV = 16'd434
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_setup,
  input  uart_ch_cfg_t wr_cfg,
  input  logic         wr_lock,
  input  logic         tx_busy,
  input  logic         rx_busy,
  output uart_ch_cfg_t shadow_cfg,
  output uart_ch_cfg_t active_cfg,
  output logic         pending,
  output logic         upd,
  output logic         shadow_lock,
  output logic         active_lock
);

  localparam uart_ch_cfg_t RstCfg = cfg_reset(RST_CLKDIV);

  chan_state_e  state_q;
  uart_ch_cfg_t shadow_q, active_q;
  logic         upd_q;
  logic         commit;

  assign commit = (state_q == StPending) && !tx_busy && !rx_busy;

  // A write landing on a commit edge goes to the shadow; active takes the old shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StClean;
      shadow_q <= RstCfg;
      active_q <= RstCfg;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        StClean: begin
          if (wr_setup) begin
            shadow_q <= wr_cfg;
            state_q  <= StPending;
          end
        end
        StPending: begin
          if (commit) begin
            active_q <= shadow_q;
            upd_q    <= 1'b1;
            if (!wr_setup) state_q <= StClean;
          end
          if (wr_setup) shadow_q <= wr_cfg;
        end
        default: state_q <= StClean;
      endcase
    end
  end

`ifdef UART_CFG_LOCK_EN
  logic shadow_lock_q, active_lock_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_lock_q <= 1'b0;
      active_lock_q <= 1'b0;
    end else begin
      if (commit) active_lock_q <= active_lock_q | shadow_lock_q;
      if (wr_setup) shadow_lock_q <= wr_lock;
    end
  end

  assign shadow_lock = shadow_lock_q;
  assign active_lock = active_lock_q;
`else
  logic unused_lock;
  assign unused_lock = wr_lock;
  assign shadow_lock = 1'b0;
  assign active_lock = 1'b0;
`endif

  assign shadow_cfg = shadow_q;
  assign active_cfg = active_q;
  assign pending    = (state_q == StPending);
  assign upd        = upd_q;

endmodule

// File: rtl/uart_cfg_bank.sv
// Multi-channel UART configuration bank: address decode, error generation, response register.
// Optional sticky SETUP lock bit under the UART_CFG_LOCK_EN macro.
module uart_cfg_bank
  import uart_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_AW      = 4,
  parameter logic [15:0] RST_CLKDIV = 16'd434
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    cfg_req_i,
  output logic                    cfg_gnt_o,
  input  logic [CH_AW+1:0]        cfg_addr_i,
  input  logic                    cfg_wen_i,
  input  logic [31:0]             cfg_wdata_i,
  output logic                    cfg_rvalid_o,
  output logic [31:0]             cfg_rdata_o,
  output logic                    cfg_err_o,
  input  logic [NUM_CH-1:0]       ch_tx_busy_i,
  input  logic [NUM_CH-1:0]       ch_rx_busy_i,
  output logic [NUM_CH*CFG_W-1:0] ch_cfg_o,
  output logic [NUM_CH-1:0]       ch_cfg_upd_o
);

  // Read muxes span the whole channel address space; unpopulated slots read as zero.
  localparam int unsigned NumSlots = 1 << CH_AW;

  logic [CH_AW-1:0] ch_idx;
  logic [1:0]       reg_sel;
  logic             ch_ok;
  logic             setup_wr;
  logic             wr_lock;
  uart_ch_cfg_t     wr_cfg;

  logic [31:0] setup_rd  [NumSlots];
  logic [31:0] status_rd [NumSlots];
  logic [31:0] active_rd [NumSlots];
  logic        slot_lock [NumSlots];

  logic        rvalid_q, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  assign {ch_idx, reg_sel} = cfg_addr_i;
  assign ch_ok             = 32'(ch_idx) < NUM_CH;
  assign cfg_gnt_o         = cfg_req_i;
  assign wr_cfg            = unpack_setup(cfg_wdata_i);

`ifdef UART_CFG_LOCK_EN
  assign wr_lock = cfg_wdata_i[15];
`else
  assign wr_lock = 1'b0;
`endif

  assign setup_wr = cfg_req_i && cfg_wen_i && ch_ok && (reg_sel == REG_SETUP) &&
                    !slot_lock[ch_idx];

  for (genvar i = 0; i < NumSlots; i++) begin : g_slot
    if (i < NUM_CH) begin : g_ch
      uart_ch_cfg_t shadow_cfg, active_cfg;
      logic         pending, shadow_lock, active_lock;

      uart_cfg_chan #(
        .RST_CLKDIV (RST_CLKDIV)
      ) u_chan (
        .clk         (clk_i),
        .rst_n       (rstn_i),
        .wr_setup    (setup_wr && (ch_idx == CH_AW'(i))),
        .wr_cfg      (wr_cfg),
        .wr_lock     (wr_lock),
        .tx_busy     (ch_tx_busy_i[i]),
        .rx_busy     (ch_rx_busy_i[i]),
        .shadow_cfg  (shadow_cfg),
        .active_cfg  (active_cfg),
        .pending     (pending),
        .upd         (ch_cfg_upd_o[i]),
        .shadow_lock (shadow_lock),
        .active_lock (active_lock)
      );

      assign ch_cfg_o[i*CFG_W +: CFG_W] = active_cfg;
      assign setup_rd[i]  = pack_setup(shadow_cfg) | {16'b0, shadow_lock, 15'b0};
      assign active_rd[i] = pack_setup(active_cfg) | {16'b0, active_lock, 15'b0};
      assign status_rd[i] = {28'b0, active_lock, ch_rx_busy_i[i], ch_tx_busy_i[i], pending};
      assign slot_lock[i] = active_lock;
    end else begin : g_empty
      assign setup_rd[i]  = '0;
      assign active_rd[i] = '0;
      assign status_rd[i] = '0;
      assign slot_lock[i] = 1'b0;
    end
  end

  always_comb begin
    err_d   = 1'b0;
    rdata_d = '0;
    if (!ch_ok) begin
      err_d = 1'b1;
    end else begin
      case (reg_sel)
        REG_SETUP: begin
          if (cfg_wen_i) err_d = slot_lock[ch_idx];
          else rdata_d = setup_rd[ch_idx];
        end
        REG_STATUS: begin
          if (cfg_wen_i) err_d = 1'b1;
          else rdata_d = status_rd[ch_idx];
        end
        REG_ACTIVE: begin
          if (cfg_wen_i) err_d = 1'b1;
          else rdata_d = active_rd[ch_idx];
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= cfg_req_i;
      err_q    <= cfg_req_i && err_d;
      rdata_q  <= cfg_req_i ? rdata_d : 32'd0;
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_err_o    = err_q;
  assign cfg_rdata_o  = rdata_q;

endmodule

// File: doc/uart_cfg_bank.md
Name: uart_cfg_bank

Overview:
- Multi-channel UART configuration register bank.
- Sits between the uDMA peripheral register bus and NUM_CH UART TX/RX cores.
- Bus writes land in a per-channel shadow register. The shadow is committed to the active configuration only when that channel's TX and RX are both idle, so a frame in flight never sees its divider or format change.
- Successor to the single-channel fixed setup register; adds channel count, a shadow/commit scheme, status readback and bus error reporting.

Parameters:
- NUM_CH, 4, number of UART channels (1..16).
- CH_AW, 4, channel-index address bits; must satisfy NUM_CH <= 2**CH_AW.
- RST_CLKDIV, 16'd434, reset clock divider for every channel.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset, asynchronous assert, active-low
- cfg_req_i  in  1  bus request
- cfg_gnt_o  out  1  bus grant
- cfg_addr_i  in  CH_AW+2  {channel, reg[1:0]} word address
- cfg_wen_i  in  1  1=write, 0=read
- cfg_wdata_i  in  32  write data
- cfg_rvalid_o  out  1  response valid
- cfg_rdata_o  out  32  read data
- cfg_err_o  out  1  response error, qualified by cfg_rvalid_o
- ch_tx_busy_i  in  NUM_CH  per-channel TX frame in progress
- ch_rx_busy_i  in  NUM_CH  per-channel RX frame in progress
- ch_cfg_o  out  NUM_CH*22  packed active config per channel
- ch_cfg_upd_o  out  NUM_CH  1-cycle pulse on active config update

Behaviour:
- Reset values:
  - cfg_rvalid_o=0, cfg_rdata_o=0, cfg_err_o=0, ch_cfg_upd_o=0.
  - Every active and shadow config = {clkdiv=RST_CLKDIV, tx_en=0, rx_en=0, stop2=0, parity_en=0, bits=2'b11}.
  - All channels in CLEAN.
- cfg_gnt_o = cfg_req_i, combinational; the bank never stalls.
- Response: cfg_rvalid_o asserts exactly 1 cycle after an accepted request, for 1 cycle. Reads and writes both respond.
- Register map (reg field):
  - 0 SETUP (RW, reads shadow): [31:16] clkdiv, [9] rx_en, [8] tx_en, [3] stop2, [2:1] bits (00=5 .. 11=8), [0] parity_en.
  - 1 STATUS (RO): [0] pending, [1] tx_busy, [2] rx_busy. A write is ignored with err=1.
  - 2 ACTIVE (RO): active config, same layout as SETUP. A write gives err=1.
  - 3: reserved, err=1, rdata=0.
- A channel index >= NUM_CH gives err=1, rdata=0, and no state change.
- Per-channel FSM:
  - CLEAN -> PENDING on a SETUP write; the shadow is loaded the same edge.
  - In PENDING with tx_busy=0 and rx_busy=0 at the sampling edge: active <= shadow, ch_cfg_upd_o pulses the next cycle, state -> CLEAN.
  - In PENDING while busy: hold indefinitely.
  - A SETUP write in PENDING overwrites the shadow and stays PENDING.
- Simultaneous SETUP write and commit on the same edge:
  - active takes the pre-write shadow;
  - shadow takes the new data;
  - state stays PENDING;
  - the upd pulse is still issued.
- ch_cfg_o packing per channel, LSB first: [0] parity_en, [2:1] bits, [3] stop2, [4] tx_en, [5] rx_en, [21:6] clkdiv. It is driven directly from active flops.
- clkdiv is 16-bit. Writing clkdiv=0 is stored as 1, so the divider never has a zero period.
- Reset asserted mid-operation: all state returns to reset values asynchronously, pending writes are discarded, and an outstanding response is dropped (rvalid=0).

Optional Feature:
- UART_CFG_LOCK_EN: adds SETUP bit [31]... no, bit [15] lock, sticky until reset.
  - With the macro, once lock=1 in the active config, further SETUP writes to that channel give err=1 with no state change; STATUS bit [3] reads lock.
  - Without the macro, bit [15] is reserved, reads 0 and is ignored; STATUS bit [3] reads 0.
  - ch_cfg_o width is unchanged in both builds.

Decomposition:
- Shared package uart_cfg_pkg holds:
  - constants REG_SETUP=2'd0, REG_STATUS=2'd1, REG_ACTIVE=2'd2, CFG_W=22;
  - packed struct uart_ch_cfg_t;
  - the reset-value constant;
  - functions pack_setup/unpack_setup between the 32-bit word and the struct.
- One sub-module, uart_cfg_chan: shadow, active, FSM and upd pulse for one channel, instantiated NUM_CH times by generate.
- The top level holds address decode, error generation and the response register.

Test Plan:
- Reset -> every ch_cfg_o clkdiv=434, bits=3, tx_en=rx_en=0; a read of ch0 ACTIVE returns 0x01B2_0006 one cycle later, err=0.
- Idle ch1, write SETUP 0x0064_0307 -> next edge PENDING; active becomes clkdiv=100, tx_en=rx_en=1, bits=3, parity=1; upd[1] pulses once.
- ch2 tx_busy=1 held 50 cycles, SETUP write 0x0010_0100 -> STATUS bit0=1 throughout, active unchanged; tx_busy falls -> commit on the next edge with one upd pulse.
- SETUP write coincident with a commit edge on ch0 -> active takes the old shadow, STATUS pending=1, new value commits on the following idle edge, two upd pulses in total.
- Access to channel index 5 with NUM_CH=4, plus write to reg 3 -> rvalid=1, err=1, rdata=0, no ch_cfg_o change.
- SETUP write with clkdiv=0 -> active clkdiv=1; with UART_CFG_LOCK_EN, write lock=1 then another write -> err=1 and active unchanged.
